// File: rtl/seq_fsm_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_fsm_gen_if
// Purpose  : Control and status bundle for the seq_fsm_gen sequence generator.
//            The master side drives stepping, loading, table writes and error
//            clearing. The slave side (the generator) returns the current
//            state, the Moore output word, the wrap pulse and the sticky error.
// Ports    : master -> en, load, load_state, cfg_we, cfg_addr, cfg_next,
//                      cfg_out, err_clr
//            slave  -> state_o, y, wrap, err
// Revision : 1.0  initial release
// ============================================================================
interface seq_fsm_gen_if #(
  parameter int N_STATES = 7,
  parameter int OUT_W    = 2
);
  localparam int SW = ($clog2(N_STATES) < 1) ? 1 : $clog2(N_STATES);

  logic             en;
  logic             load;
  logic [SW-1:0]    load_state;
  logic             cfg_we;
  logic [SW-1:0]    cfg_addr;
  logic [SW-1:0]    cfg_next;
  logic [OUT_W-1:0] cfg_out;
  logic             err_clr;
  logic [SW-1:0]    state_o;
  logic [OUT_W-1:0] y;
  logic             wrap;
  logic             err;

  modport master (
    output en, load, load_state, cfg_we, cfg_addr, cfg_next, cfg_out, err_clr,
    input  state_o, y, wrap, err
  );

  modport slave (
    input  en, load, load_state, cfg_we, cfg_addr, cfg_next, cfg_out, err_clr,
    output state_o, y, wrap, err
  );
endinterface
`default_nettype wire

// File: rtl/seq_fsm_gen.sv
`default_nettype none
// ============================================================================
// Module   : seq_fsm_gen
// Purpose  : Run-time programmable Moore sequence generator. Walks a
//            next-state table held in flops and presents the per-state output
//            word. Supports direct load of a state, stepping under en, table
//            writes concurrent with stepping, and a sticky illegal-value flag.
// Ports    : clk    - clock, rising edge
//            reset  - synchronous active-high reset
//            bus    - seq_fsm_gen_if.slave (control in, state/y/wrap/err out)
// Revision : 1.0  initial release
// ============================================================================
module seq_fsm_gen #(
  parameter int N_STATES = 7,
  parameter int OUT_W    = 2
) (
  input  wire logic    clk,
  input  wire logic    reset,
  seq_fsm_gen_if.slave bus
);
  localparam int SW = ($clog2(N_STATES) < 1) ? 1 : $clog2(N_STATES);

  // State count widened by one bit so 256 states still fits the compare.
  localparam logic [SW:0] c_n_states = (SW + 1)'(N_STATES);

  logic [SW-1:0]    r_state;
  logic [SW-1:0]    r_next_tab [N_STATES];
  logic [OUT_W-1:0] r_out_tab  [N_STATES];
  logic             r_wrap;
  logic             r_err;

  logic             w_state_ok;
  logic             w_load_ok;
  logic             w_addr_ok;
  logic             w_next_ok;
  logic             w_wr_ok;
  logic [SW-1:0]    w_adv_dest;
  logic             w_new_err;

  assign w_state_ok = ({1'b0, r_state}        < c_n_states);
  assign w_load_ok  = ({1'b0, bus.load_state} < c_n_states);
  assign w_addr_ok  = ({1'b0, bus.cfg_addr}   < c_n_states);
  assign w_next_ok  = ({1'b0, bus.cfg_next}   < c_n_states);
  assign w_wr_ok    = bus.cfg_we && w_addr_ok && w_next_ok;

  // A state outside the table (only reachable with non-power-of-2 N_STATES
  // after an upset) is recovered to 0 on the next advance.
  assign w_adv_dest = w_state_ok ? r_next_tab[r_state] : '0;

  always_comb begin
    w_new_err = 1'b0;
    if (bus.cfg_we && !(w_addr_ok && w_next_ok)) begin
      w_new_err = 1'b1;
    end
    if (bus.load) begin
      if (!w_load_ok) begin
        w_new_err = 1'b1;
      end
    end else if (bus.en && !w_state_ok) begin
      w_new_err = 1'b1;
    end
  end

  // State register and wrap pulse. The advance reads the table before any
  // same-edge write lands, so a write to the current entry applies next pass.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= '0;
      r_wrap  <= 1'b0;
    end else if (bus.load) begin
      r_state <= w_load_ok ? bus.load_state : '0;
      r_wrap  <= 1'b0;
    end else if (bus.en) begin
      r_state <= w_adv_dest;
      r_wrap  <= (w_adv_dest == '0);
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  // Table storage; reset restores the plain incrementing cycle 0..N-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_STATES; i++) begin
        r_next_tab[i] <= SW'((i + 1) % N_STATES);
        r_out_tab[i]  <= '0;
      end
    end else if (w_wr_ok) begin
      r_next_tab[bus.cfg_addr] <= bus.cfg_next;
      r_out_tab[bus.cfg_addr]  <= bus.cfg_out;
    end
  end

  // Sticky error: a fresh error wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_new_err) begin
      r_err <= 1'b1;
    end else if (bus.err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign bus.state_o = r_state;
  assign bus.y       = w_state_ok ? r_out_tab[r_state] : '0;
  assign bus.wrap    = r_wrap;
  assign bus.err     = r_err;
endmodule
`default_nettype wire

// File: tb/tb_seq_fsm_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_fsm_gen
// Purpose  : Directed self-checking bench for seq_fsm_gen (N_STATES=7,
//            OUT_W=2) with hand-computed expected values.
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_fsm_gen;
  localparam int N_STATES = 7;
  localparam int OUT_W    = 2;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  seq_fsm_gen_if #(.N_STATES(N_STATES), .OUT_W(OUT_W)) bus ();

  seq_fsm_gen #(.N_STATES(N_STATES), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.en = 1'b0; bus.load = 1'b0; bus.load_state = '0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_next = '0; bus.cfg_out = '0;
    bus.err_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (bus.state_o !== 3'd0) begin n_bad++; $display("FAIL reset_state got=%0d exp=0", bus.state_o); end
    n_cmp++; if (bus.y !== 2'd0)       begin n_bad++; $display("FAIL reset_y got=%0d exp=0", bus.y); end
    n_cmp++; if (bus.wrap !== 1'b0)    begin n_bad++; $display("FAIL reset_wrap got=%b exp=0", bus.wrap); end
    n_cmp++; if (bus.err !== 1'b0)     begin n_bad++; $display("FAIL reset_err got=%b exp=0", bus.err); end
  endtask

  task automatic test_default_run();
    logic [2:0] exp_s [8];
    exp_s = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd1};
    bus.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp++; if (bus.state_o !== exp_s[i]) begin n_bad++; $display("FAIL dflt_state[%0d] got=%0d exp=%0d", i, bus.state_o, exp_s[i]); end
      n_cmp++; if (bus.y !== 2'd0) begin n_bad++; $display("FAIL dflt_y[%0d] got=%0d exp=0", i, bus.y); end
      n_cmp++; if (bus.wrap !== (i == 6)) begin n_bad++; $display("FAIL dflt_wrap[%0d] got=%b exp=%b", i, bus.wrap, (i == 6)); end
    end
    bus.en = 1'b0;
  endtask

  task automatic test_program();
    logic [2:0] wa [7];
    logic [2:0] wn [7];
    logic [1:0] wo [7];
    logic [2:0] exp_s [7];
    logic [1:0] exp_y [7];
    wa = '{3'd0, 3'd4, 3'd6, 3'd3, 3'd5, 3'd2, 3'd1};
    wn = '{3'd4, 3'd6, 3'd3, 3'd5, 3'd2, 3'd1, 3'd0};
    wo = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
    exp_s = '{3'd4, 3'd6, 3'd3, 3'd5, 3'd2, 3'd1, 3'd0};
    exp_y = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};
    for (int i = 0; i < 7; i++) begin
      bus.cfg_we = 1'b1; bus.cfg_addr = wa[i]; bus.cfg_next = wn[i]; bus.cfg_out = wo[i];
      step();
    end
    bus.cfg_we = 1'b0;
    bus.load = 1'b1; bus.load_state = 3'd0;
    step();
    bus.load = 1'b0;
    n_cmp++; if (bus.y !== 2'd1)    begin n_bad++; $display("FAIL prog_load0_y got=%0d exp=1", bus.y); end
    n_cmp++; if (bus.wrap !== 1'b0) begin n_bad++; $display("FAIL prog_load0_wrap got=%b exp=0", bus.wrap); end
    bus.en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      n_cmp++; if (bus.state_o !== exp_s[i]) begin n_bad++; $display("FAIL prog_state[%0d] got=%0d exp=%0d", i, bus.state_o, exp_s[i]); end
      n_cmp++; if (bus.y !== exp_y[i]) begin n_bad++; $display("FAIL prog_y[%0d] got=%0d exp=%0d", i, bus.y, exp_y[i]); end
      n_cmp++; if (bus.wrap !== (i == 6)) begin n_bad++; $display("FAIL prog_wrap[%0d] got=%b exp=%b", i, bus.wrap, (i == 6)); end
    end
  endtask

  task automatic test_load_priority();
    // en is still high from the previous run; load must win.
    bus.load = 1'b1; bus.load_state = 3'd5;
    step();
    n_cmp++; if (bus.state_o !== 3'd5) begin n_bad++; $display("FAIL ldpri_state got=%0d exp=5", bus.state_o); end
    n_cmp++; if (bus.wrap !== 1'b0)    begin n_bad++; $display("FAIL ldpri_wrap got=%b exp=0", bus.wrap); end
    n_cmp++; if (bus.err !== 1'b0)     begin n_bad++; $display("FAIL ldpri_err got=%b exp=0", bus.err); end
    bus.load_state = 3'd7;
    step();
    n_cmp++; if (bus.state_o !== 3'd0) begin n_bad++; $display("FAIL ldbad_state got=%0d exp=0", bus.state_o); end
    n_cmp++; if (bus.err !== 1'b1)     begin n_bad++; $display("FAIL ldbad_err got=%b exp=1", bus.err); end
    n_cmp++; if (bus.wrap !== 1'b0)    begin n_bad++; $display("FAIL ldbad_wrap got=%b exp=0", bus.wrap); end
    bus.load = 1'b0; bus.en = 1'b0; bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL ldbad_clr got=%b exp=0", bus.err); end
  endtask

  task automatic test_write_during_advance();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.load = 1'b1; bus.load_state = 3'd2;
    step();
    bus.load = 1'b0;
    // Advance out of 2 while rewriting entry 2: old next (3) is used.
    bus.en = 1'b1;
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd2; bus.cfg_next = 3'd0; bus.cfg_out = 2'd3;
    step();
    bus.cfg_we = 1'b0; bus.en = 1'b0;
    n_cmp++; if (bus.state_o !== 3'd3) begin n_bad++; $display("FAIL wadv_state got=%0d exp=3", bus.state_o); end
    n_cmp++; if (bus.y !== 2'd0)       begin n_bad++; $display("FAIL wadv_y got=%0d exp=0", bus.y); end
    n_cmp++; if (bus.wrap !== 1'b0)    begin n_bad++; $display("FAIL wadv_wrap got=%b exp=0", bus.wrap); end
    bus.load = 1'b1; bus.load_state = 3'd2;
    step();
    bus.load = 1'b0;
    n_cmp++; if (bus.y !== 2'd3) begin n_bad++; $display("FAIL wadv_y2 got=%0d exp=3", bus.y); end
    bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    n_cmp++; if (bus.state_o !== 3'd0) begin n_bad++; $display("FAIL wadv_pass2 got=%0d exp=0", bus.state_o); end
    n_cmp++; if (bus.wrap !== 1'b1)    begin n_bad++; $display("FAIL wadv_wrap2 got=%b exp=1", bus.wrap); end
    step();
    n_cmp++; if (bus.wrap !== 1'b0)    begin n_bad++; $display("FAIL wadv_wrap3 got=%b exp=0", bus.wrap); end
  endtask

  task automatic test_illegal_write();
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd1; bus.cfg_next = 3'd7; bus.cfg_out = 2'd3;
    step();
    bus.cfg_we = 1'b0;
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL illw_err got=%b exp=1", bus.err); end
    bus.load = 1'b1; bus.load_state = 3'd1;
    step();
    bus.load = 1'b0;
    n_cmp++; if (bus.y !== 2'd0) begin n_bad++; $display("FAIL illw_out_kept got=%0d exp=0", bus.y); end
    bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    n_cmp++; if (bus.state_o !== 3'd2) begin n_bad++; $display("FAIL illw_next_kept got=%0d exp=2", bus.state_o); end
    bus.err_clr = 1'b1; bus.cfg_we = 1'b1; bus.cfg_addr = 3'd7; bus.cfg_next = 3'd0;
    step();
    bus.cfg_we = 1'b0;
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL illw_clr_race got=%b exp=1", bus.err); end
    step();
    bus.err_clr = 1'b0;
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL illw_clr got=%b exp=0", bus.err); end
  endtask

  task automatic test_reset_midrun();
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_next = 3'd5; bus.cfg_out = 2'd2;
    step();
    bus.cfg_addr = 3'd4; bus.cfg_next = 3'd4; bus.cfg_out = 2'd1;
    bus.load = 1'b1; bus.load_state = 3'd7;
    step();
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_err got=%b exp=1", bus.err); end
    // Reset while a table write and an illegal load are presented.
    bus.cfg_addr = 3'd3; bus.cfg_next = 3'd0; bus.cfg_out = 2'd1;
    bus.en = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.cfg_we = 1'b0; bus.load = 1'b0; bus.en = 1'b0;
    n_cmp++; if (bus.state_o !== 3'd0) begin n_bad++; $display("FAIL rmid_state got=%0d exp=0", bus.state_o); end
    n_cmp++; if (bus.y !== 2'd0)       begin n_bad++; $display("FAIL rmid_y got=%0d exp=0", bus.y); end
    n_cmp++; if (bus.err !== 1'b0)     begin n_bad++; $display("FAIL rmid_err got=%b exp=0", bus.err); end
    n_cmp++; if (bus.wrap !== 1'b0)    begin n_bad++; $display("FAIL rmid_wrap got=%b exp=0", bus.wrap); end
    bus.en = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      n_cmp++; if (bus.state_o !== 3'(i % 7)) begin n_bad++; $display("FAIL rmid_run[%0d] got=%0d exp=%0d", i, bus.state_o, i % 7); end
      n_cmp++; if (bus.y !== 2'd0) begin n_bad++; $display("FAIL rmid_run_y[%0d] got=%0d exp=0", i, bus.y); end
    end
    bus.en = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    idle_inputs();
    #2;
    test_reset();
    test_default_run();
    test_program();
    test_load_priority();
    test_write_during_advance();
    test_illegal_write();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/seq_fsm_gen.md
# seq_fsm_gen

Parametrised, run-time programmable Moore sequence generator. It steps through up to N_STATES binary-encoded states along a next-state table and drives a per-state output word. Software or upstream control can load the table, jump to a state and pause stepping. It is the general-purpose successor to the team's fixed-sequence state machines, for use wherever a cyclic pattern of output codes must be produced on a clock.

## Interface
- N_STATES, 7: number of legal states, 2..256; state encoding width SW = max(1, clog2(N_STATES)), derived.
- OUT_W, 2: output word width, 1..32.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  advance one state per cycle while high.
- load  in  1  jump to load_state this cycle.
- load_state  in  SW  target state for load.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  SW  table entry to write.
- cfg_next  in  SW  next-state value for entry cfg_addr.
- cfg_out  in  OUT_W  output value for entry cfg_addr.
- err_clr  in  1  clear sticky error flag.
- state_o  out  SW  current state register.
- y  out  OUT_W  Moore output: out_tab[state_o].
- wrap  out  1  one-cycle pulse after an en-advance that lands in state 0.
- err  out  1  sticky illegal-value flag.

## Operation
- Storage: state register (SW bits); table of N_STATES entries {next_tab (SW), out_tab (OUT_W)} in flops.
- Reset (reset=1 at edge): state_o=0; next_tab[i]=(i+1) mod N_STATES; out_tab[i]=0; wrap=0; err=0. So y=0 out of reset. Reset overrides every other input, including an in-flight table write.
- State update priority per cycle: reset > load > en > hold.
  - load=1: if load_state < N_STATES, state_o <= load_state; else state_o <= 0 and err set.
  - load=0, en=1: state_o <= next_tab[state_o] (pre-write table value).
  - otherwise state_o holds.
- Table write: when cfg_we=1, cfg_addr < N_STATES and cfg_next < N_STATES, the entry is written at the edge. If either is out of range, the write is dropped entirely and err is set. A write is independent of load/en and happens in the same cycle as any state update.
- Same-cycle write and advance through the written entry: the advance uses the old next_tab value. The new value applies from the next cycle.
- y is combinational from state_o and out_tab. A write to out_tab[state_o] changes y in the cycle after the write edge.
- wrap: registered. It is 1 for exactly the cycle after an en-advance whose destination is 0, and 0 otherwise. Load to 0 and reset never pulse wrap. A self-loop 0->0 pulses wrap on every advance.
- err: set by an illegal load or an illegal write. err_clr=1 clears it unless a new error occurs in the same cycle, in which case err stays 1.
- Defensive: if state_o ever holds a value >= N_STATES (non-power-of-2 N_STATES), the next en-advance goes to 0 and sets err. y for such a state is 0.

## Timing
- Latency: en/load at edge k gives the new state_o and y after edge k. wrap is high during cycle k+1.
- No handshake; en may be held high continuously for one state per cycle.
- Table write visible to advance and y one cycle after the write edge.
- Reset takes effect at the first rising edge with reset=1. Outputs are valid from the following cycle.

## Test plan
- Reset then en=1 for 8 cycles, N_STATES=7, default table -> state_o 1,2,3,4,5,6,0,1; y=0 throughout; wrap high only in the cycle after 6->0.
- Program entries 0->4, 4->6, 6->3, 3->5, 5->2, 2->1, 1->0 with out 1,1,0,1,0,0,0 for states 0,4,6,3,5,2,1 respectively, then run -> state_o 4,6,3,5,2,1,0; y follows 1,0,1,0,0,0,1.
- load=1, load_state=5 with en=1 the same cycle -> state_o=5 (load wins), wrap=0. Then load_state=7 -> state_o=0, err=1, wrap=0.
- cfg_we writes entry 2 (next=0) in the same cycle state 2 advances -> goes to old next_tab[2]=3. Next pass through 2 goes to 0 with wrap pulse.
- Illegal write, cfg_next=7 -> table unchanged, err=1. err_clr with a concurrent illegal write -> err stays 1. err_clr alone -> err=0.
- Assert reset mid-run after reprogramming -> state_o=0, y=0, table restored to (i+1) mod N, err=0, wrap=0.
